// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - IF/WB/EX-facing signal bundle for the decode stage
interface id_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int PC_W   = 32
);
    logic              if_valid;
    logic [31:0]       if_inst;
    logic [PC_W-1:0]   if_pc;
    logic              id_ready;

    logic              wb_we;
    logic [REG_AW-1:0] wb_waddr;
    logic [DATA_W-1:0] wb_wdata;

    logic              ex_ready;
    logic              flush;
    logic              ex_valid;
    logic [PC_W-1:0]   ex_pc;
    logic [DATA_W-1:0] ex_rdata1;
    logic [DATA_W-1:0] ex_rdata2;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_dest;
    logic [5:0]        ex_funct;
    logic [2:0]        ex_aluop;
    logic              ex_alusrc;
    logic              ex_regwrite;
    logic              ex_memread;
    logic              ex_memwrite;
    logic              ex_memtoreg;
    logic              ex_branch;
    logic              ex_illegal;

    modport master (
        output if_valid, if_inst, if_pc, wb_we, wb_waddr, wb_wdata, ex_ready, flush,
        input  id_ready, ex_valid, ex_pc, ex_rdata1, ex_rdata2, ex_imm, ex_rs, ex_rt,
               ex_dest, ex_funct, ex_aluop, ex_alusrc, ex_regwrite, ex_memread,
               ex_memwrite, ex_memtoreg, ex_branch, ex_illegal
    );

    modport slave (
        input  if_valid, if_inst, if_pc, wb_we, wb_waddr, wb_wdata, ex_ready, flush,
        output id_ready, ex_valid, ex_pc, ex_rdata1, ex_rdata2, ex_imm, ex_rs, ex_rt,
               ex_dest, ex_funct, ex_aluop, ex_alusrc, ex_regwrite, ex_memread,
               ex_memwrite, ex_memtoreg, ex_branch, ex_illegal
    );
endinterface

// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS decode stage with bypassed register file and ID/EX register
module id_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int PC_W   = 32
) (
    input  logic     clk,
    input  logic     resetn,
    id_stage_if.slave bus
);
    localparam int NREG = 2 ** REG_AW;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [REG_AW-1:0] raddr_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        word_t           rdata1;
        word_t           rdata2;
        word_t           imm;
        raddr_t          rs;
        raddr_t          rt;
        raddr_t          dest;
        logic [5:0]      funct;
        logic [2:0]      aluop;
        logic            alusrc;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            branch;
        logic            illegal;
    } idex_t;

    // Narrows or zero-extends a 5-bit MIPS register field to REG_AW bits.
    function automatic raddr_t reg_field(input logic [4:0] f);
        raddr_t r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            if (i < REG_AW) r[i] = f[i];
        end
        return r;
    endfunction

    word_t  regs_q [NREG];
    word_t  regs_d [NREG];
    idex_t  idex_q, idex_d, dec;
    logic   ex_valid_q, ex_valid_d;

    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [15:0] imm16;
    raddr_t      rs, rt, rd;
    word_t       rdata1, rdata2, imm_s, imm_z;
    logic        use_rs, use_rt, hazard;
    logic        unused_shamt;

    assign inst         = bus.if_inst;
    assign opcode       = inst[31:26];
    assign imm16        = inst[15:0];
    assign rs           = reg_field(inst[25:21]);
    assign rt           = reg_field(inst[20:16]);
    assign rd           = reg_field(inst[15:11]);
    assign unused_shamt = ^inst[10:6];
    assign imm_s        = {{(DATA_W-16){imm16[15]}}, imm16};
    assign imm_z        = {{(DATA_W-16){1'b0}}, imm16};

    always_comb begin
        regs_d = regs_q;
        if (bus.wb_we && bus.wb_waddr != '0) regs_d[bus.wb_waddr] = bus.wb_wdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Same-cycle WB bypass so an instruction never reads a value one write stale.
    assign rdata1 = (rs == '0) ? '0 :
                    (bus.wb_we && bus.wb_waddr == rs) ? bus.wb_wdata : regs_q[rs];
    assign rdata2 = (rt == '0) ? '0 :
                    (bus.wb_we && bus.wb_waddr == rt) ? bus.wb_wdata : regs_q[rt];

    always_comb begin
        dec        = '0;
        use_rs     = 1'b0;
        use_rt     = 1'b0;
        dec.pc     = bus.if_pc;
        dec.rdata1 = rdata1;
        dec.rdata2 = rdata2;
        dec.rs     = rs;
        dec.rt     = rt;
        dec.funct  = inst[5:0];
        dec.imm    = imm_s;
        case (opcode)
            OP_RTYPE: begin
                dec.dest = rd; dec.regwrite = 1'b1; dec.aluop = 3'b010;
                use_rs = 1'b1; use_rt = 1'b1;
            end
            OP_LW: begin
                dec.dest = rt; dec.regwrite = 1'b1; dec.memread = 1'b1;
                dec.memtoreg = 1'b1; dec.alusrc = 1'b1; use_rs = 1'b1;
            end
            OP_SW: begin
                dec.memwrite = 1'b1; dec.alusrc = 1'b1;
                use_rs = 1'b1; use_rt = 1'b1;
            end
            OP_BEQ: begin
                dec.branch = 1'b1; dec.aluop = 3'b001;
                use_rs = 1'b1; use_rt = 1'b1;
            end
            OP_ADDI: begin
                dec.dest = rt; dec.regwrite = 1'b1; dec.alusrc = 1'b1; use_rs = 1'b1;
            end
            OP_ORI: begin
                dec.dest = rt; dec.regwrite = 1'b1; dec.alusrc = 1'b1;
                dec.aluop = 3'b011; dec.imm = imm_z; use_rs = 1'b1;
            end
            OP_LUI: begin
                dec.dest = rt; dec.regwrite = 1'b1; dec.alusrc = 1'b1;
                dec.aluop = 3'b100; dec.imm = imm_z << 16;
            end
            default: dec.illegal = 1'b1;
        endcase
        // A write to r0 is a no-op, so drop it here and keep EX forwarding clean.
        if (dec.dest == '0) dec.regwrite = 1'b0;
        if (!dec.regwrite)  dec.dest     = '0;
    end

    assign hazard = ex_valid_q && idex_q.memread && (idex_q.dest != '0) && bus.if_valid &&
                    ((use_rs && idex_q.dest == rs) || (use_rt && idex_q.dest == rt));

    assign bus.id_ready = bus.flush | (bus.ex_ready & ~hazard);

    always_comb begin
        idex_d     = idex_q;
        ex_valid_d = ex_valid_q;
        if (bus.flush) begin
            ex_valid_d = 1'b0;
        end else if (bus.ex_ready) begin
            if (hazard) begin
                ex_valid_d = 1'b0;
            end else begin
                idex_d     = dec;
                ex_valid_d = bus.if_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idex_q     <= '0;
            ex_valid_q <= 1'b0;
        end else begin
            idex_q     <= idex_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_pc       = idex_q.pc;
    assign bus.ex_rdata1   = idex_q.rdata1;
    assign bus.ex_rdata2   = idex_q.rdata2;
    assign bus.ex_imm      = idex_q.imm;
    assign bus.ex_rs       = idex_q.rs;
    assign bus.ex_rt       = idex_q.rt;
    assign bus.ex_dest     = idex_q.dest;
    assign bus.ex_funct    = idex_q.funct;
    assign bus.ex_aluop    = idex_q.aluop;
    assign bus.ex_alusrc   = idex_q.alusrc;
    assign bus.ex_memtoreg = idex_q.memtoreg;
    assign bus.ex_regwrite = ex_valid_q & idex_q.regwrite;
    assign bus.ex_memread  = ex_valid_q & idex_q.memread;
    assign bus.ex_memwrite = ex_valid_q & idex_q.memwrite;
    assign bus.ex_branch   = ex_valid_q & idex_q.branch;
    assign bus.ex_illegal  = ex_valid_q & idex_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage
module tb_id_stage;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    id_stage_if #(.DATA_W(32), .REG_AW(5), .PC_W(32)) bus ();

    id_stage #(.DATA_W(32), .REG_AW(5), .PC_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [5:0]  funct;
        logic [2:0]  aluop;
        logic        alusrc, regwrite, memread, memwrite, memtoreg, branch, illegal;
    } ex_t;

    typedef struct {
        ex_t e;
        ex_t m;
    } sb_t;

    localparam ex_t FULL = '1;

    sb_t sb_q[$];
    int  errors = 0;
    int  checks = 0;
    sb_t mon_s;
    ex_t mon_a;

    function automatic ex_t mk(input logic [31:0] pc, rd1, rd2, imm,
                               input logic [4:0] rs, rt, dest, input logic [5:0] funct,
                               input logic [2:0] aluop, input logic [6:0] ctl);
        ex_t e;
        e.pc = pc; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
        e.rs = rs; e.rt = rt; e.dest = dest; e.funct = funct; e.aluop = aluop;
        {e.alusrc, e.regwrite, e.memread, e.memwrite, e.memtoreg, e.branch, e.illegal} = ctl;
        return e;
    endfunction

    function automatic ex_t actual();
        ex_t a;
        a.pc = bus.ex_pc; a.rd1 = bus.ex_rdata1; a.rd2 = bus.ex_rdata2; a.imm = bus.ex_imm;
        a.rs = bus.ex_rs; a.rt = bus.ex_rt; a.dest = bus.ex_dest;
        a.funct = bus.ex_funct; a.aluop = bus.ex_aluop;
        a.alusrc = bus.ex_alusrc; a.regwrite = bus.ex_regwrite; a.memread = bus.ex_memread;
        a.memwrite = bus.ex_memwrite; a.memtoreg = bus.ex_memtoreg;
        a.branch = bus.ex_branch; a.illegal = bus.ex_illegal;
        return a;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every instruction EX accepts is compared against the oldest expectation.
    always @(negedge clk) begin
        if (resetn && bus.ex_valid && bus.ex_ready) begin
            mon_a = actual();
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc %0h expected none", mon_a.pc);
            end else begin
                mon_s = sb_q.pop_front();
                if (((mon_a ^ mon_s.e) & mon_s.m) !== '0) begin
                    errors++;
                    $display("FAIL sb_pc_%0h: got %0h expected %0h", mon_s.e.pc, mon_a, mon_s.e);
                end
            end
        end
    end

    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic push,
                        input ex_t e, input ex_t m, output int stalls, output logic v_at_acc);
        sb_t s;
        bus.if_inst  = inst;
        bus.if_pc    = pc;
        bus.if_valid = 1'b1;
        stalls   = 0;
        v_at_acc = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.id_ready) begin
                v_at_acc = bus.ex_valid;
                if (push) begin
                    s.e = e; s.m = m;
                    sb_q.push_back(s);
                end
                @(posedge clk);
                #1;
                bus.if_valid = 1'b0;
                return;
            end
            stalls++;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got no accept expected accept of %h", inst);
        bus.if_valid = 1'b0;
    endtask

    initial begin
        int   st;
        logic va;
        ex_t  mi;

        mi = '0;
        mi.pc = '1; mi.rs = '1; mi.rt = '1; mi.dest = '1; mi.funct = '1;
        mi.regwrite = 1'b1; mi.memread = 1'b1; mi.memwrite = 1'b1;
        mi.branch = 1'b1; mi.illegal = 1'b1;

        bus.if_valid = 1'b0; bus.if_inst = '0; bus.if_pc = '0;
        bus.wb_we = 1'b0; bus.wb_waddr = '0; bus.wb_wdata = '0;
        bus.ex_ready = 1'b1; bus.flush = 1'b0;

        @(posedge clk); #1;
        check("rst_ex", actual(), '0);
        check("rst_valid", bus.ex_valid, 1'b0);
        check("rst_ready", bus.id_ready, 1'b1);
        resetn = 1'b1;

        bus.wb_we = 1'b1; bus.wb_waddr = 5'd1; bus.wb_wdata = 32'd5;
        @(posedge clk); #1;
        bus.wb_we = 1'b0;

        send(32'h2022FFFF, 32'h100, 1'b1,
             mk(32'h100, 32'd5, 32'd0, 32'hFFFFFFFF, 5'd1, 5'd2, 5'd2, 6'h3F, 3'b000, 7'b1100000),
             FULL, st, va);

        send(32'h8C230000, 32'h104, 1'b1,
             mk(32'h104, 32'd5, 32'd0, 32'd0, 5'd1, 5'd3, 5'd3, 6'h00, 3'b000, 7'b1110100),
             FULL, st, va);
        send(32'h00612020, 32'h108, 1'b1,
             mk(32'h108, 32'd0, 32'd5, 32'h2020, 5'd3, 5'd1, 5'd4, 6'h20, 3'b010, 7'b0100000),
             FULL, st, va);
        check("lu_stalls", st, 1);
        check("lu_bubble", va, 1'b0);

        send(32'h8C230000, 32'h10C, 1'b1,
             mk(32'h10C, 32'd5, 32'd0, 32'd0, 5'd1, 5'd3, 5'd3, 6'h00, 3'b000, 7'b1110100),
             FULL, st, va);
        send(32'h342700F0, 32'h110, 1'b1,
             mk(32'h110, 32'd5, 32'd0, 32'hF0, 5'd1, 5'd7, 5'd7, 6'h30, 3'b011, 7'b1100000),
             FULL, st, va);
        check("nodep_stalls", st, 0);
        check("nodep_valid", va, 1'b1);

        bus.wb_we = 1'b1; bus.wb_waddr = 5'd5; bus.wb_wdata = 32'hA5;
        send(32'h10A1FFFE, 32'h114, 1'b1,
             mk(32'h114, 32'hA5, 32'd5, 32'hFFFFFFFE, 5'd5, 5'd1, 5'd0, 6'h3E, 3'b001, 7'b0000010),
             FULL, st, va);
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd0; bus.wb_wdata = 32'hFF;
        @(posedge clk); #1;
        bus.wb_we = 1'b0;
        send(32'hACA00004, 32'h118, 1'b1,
             mk(32'h118, 32'hA5, 32'd0, 32'd4, 5'd5, 5'd0, 5'd0, 6'h04, 3'b000, 7'b1001000),
             FULL, st, va);
        send(32'h20200001, 32'h11C, 1'b1,
             mk(32'h11C, 32'd5, 32'd0, 32'd1, 5'd1, 5'd0, 5'd0, 6'h01, 3'b000, 7'b1000000),
             FULL, st, va);

        send(32'hFC221234, 32'h120, 1'b1,
             mk(32'h120, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2, 5'd0, 6'h34, 3'b000, 7'b0000001),
             mi, st, va);
        send(32'h3C061234, 32'h124, 1'b1,
             mk(32'h124, 32'd0, 32'd0, 32'h12340000, 5'd0, 5'd6, 5'd6, 6'h34, 3'b100, 7'b1100000),
             FULL, st, va);

        send(32'h20280003, 32'h128, 1'b0, '0, '0, st, va);
        bus.ex_ready = 1'b0;
        bus.if_inst = 32'h3C09ABCD; bus.if_pc = 32'h12C; bus.if_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_ready", bus.id_ready, 1'b0);
            check("bp_hold", {bus.ex_valid, bus.ex_dest, bus.ex_imm, bus.ex_rdata1},
                  {1'b1, 5'd8, 32'd3, 32'd5});
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        check("fl_ready", bus.id_ready, 1'b1);
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.if_valid = 1'b0;
        @(negedge clk);
        check("fl_valid", bus.ex_valid, 1'b0);
        @(posedge clk); #1;
        bus.ex_ready = 1'b1;

        send(32'h2022FFFF, 32'h200, 1'b0, '0, '0, st, va);
        bus.ex_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", bus.ex_valid, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("rst_async_ex", actual(), '0);
        check("rst_async_valid", bus.ex_valid, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b1;
        bus.ex_ready = 1'b1;
        send(32'h2022FFFF, 32'h204, 1'b1,
             mk(32'h204, 32'd0, 32'd0, 32'hFFFFFFFF, 5'd1, 5'd2, 5'd2, 6'h3F, 3'b000, 7'b1100000),
             FULL, st, va);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_stage.md
# id_stage

Parametrised instruction-decode stage with an integrated ID/EX pipeline register for the MIPS core. It decodes the instruction presented by IF, reads operands from an internal register file with write-back bypass, generates EX/MEM/WB control, and extends immediates. It detects load-use hazards against the instruction held in its own ID/EX register and stalls IF. It accepts branch flushes from EX and sits between the IF stage and the EX stage.

## Interface
- DATA_W, 32: datapath width. Must be ≥ 32; immediates are extended to DATA_W.
- REG_AW, 5: register address width. Register count is 2**REG_AW.
- PC_W, 32: PC width.

- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- if_valid  in  1  IF presents a valid instruction.
- if_inst  in  32  instruction word.
- if_pc  in  PC_W  PC of if_inst.
- id_ready  out  1  ID consumes if_inst this cycle (combinational).
- wb_we, wb_waddr[REG_AW], wb_wdata[DATA_W]  in  WB write port.
- ex_ready  in  1  EX accepts the ID/EX contents this cycle.
- flush  in  1  taken branch in EX; squash the wrong path.
- ex_valid  out  1  ID/EX register holds a valid instruction.
- ex_pc  out  PC_W.
- ex_rdata1, ex_rdata2  out  DATA_W  rs and rt operand values.
- ex_imm  out  DATA_W  extended immediate.
- ex_rs, ex_rt, ex_dest  out  REG_AW  source and destination register numbers (for EX forwarding).
- ex_funct  out  6  inst[5:0].
- ex_aluop  out  3  000 add, 001 sub, 010 R-type (use funct), 011 or, 100 pass imm.
- ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch, ex_illegal  out  1 each.

## Operation
- Register file:
  - 2**REG_AW × DATA_W registers; all cleared to 0 on reset.
  - Register 0 always reads 0; writes to it are ignored.
  - Write occurs on the clock edge when wb_we=1.
  - Reads are combinational. If wb_we=1, wb_waddr≠0 and wb_waddr equals a read address, the read returns wb_wdata in the same cycle.
- Field extraction: rs=inst[25:21], rt=inst[20:16], rd=inst[15:11], imm=inst[15:0]. Only the low REG_AW bits are used when REG_AW<5. Register fields are zero-extended when REG_AW>5.
- Decode by opcode inst[31:26]:
  - 0x00 R-type: dest=rd, regwrite, aluop=010, uses rs and rt.
  - 0x23 lw: dest=rt, regwrite, memread, memtoreg, alusrc, aluop=000, sign-extended imm, uses rs.
  - 0x2B sw: memwrite, alusrc, aluop=000, sign-extended imm, uses rs and rt.
  - 0x04 beq: branch, aluop=001, sign-extended imm, uses rs and rt.
  - 0x08 addi: dest=rt, regwrite, alusrc, aluop=000, sign-extended imm, uses rs.
  - 0x0D ori: dest=rt, regwrite, alusrc, aluop=011, zero-extended imm, uses rs.
  - 0x0F lui: dest=rt, regwrite, alusrc, aluop=100, imm={inst[15:0],16'b0} zero-extended to DATA_W; uses no sources.
  - Any other opcode: ex_illegal=1, with regwrite, memread, memwrite and branch all 0.
- Destination handling: regwrite is forced to 0 when dest=0. ex_dest=0 whenever regwrite=0.
- Load-use hazard:
  - Condition: ex_valid, ex_memread, and ex_dest≠0, and ex_dest equals a used source (rs, or rt when rt is used) of a valid if_inst.
  - While the hazard holds, id_ready=0.
- Ready: id_ready = flush | (ex_ready & ~hazard).
- ID/EX register update, highest priority first:
  1. flush=1: ex_valid←0. if_inst is discarded (id_ready=1).
  2. ex_ready=1 and hazard: ex_valid←0 (bubble). Data fields are don't-care.
  3. ex_ready=1: load all ex_* fields from decode; ex_valid←if_valid.
  4. ex_ready=0: hold all ex_* fields.
- When ex_valid=0, all control outputs (regwrite, memread, memwrite, branch, illegal) read 0.

## Timing
- Reset (asynchronous, while resetn=0): every ex_* output is 0 and all registers are 0. id_ready follows its combinational definition.
- Latency: an instruction accepted at edge N appears on ex_* after edge N. A load-use pair costs exactly one bubble cycle.
- Operand values are sampled at acceptance, including any same-cycle WB bypass. They are not refreshed while the ID/EX register holds under ex_ready=0; EX forwarding covers that case.
- flush together with ex_ready=0 still clears ex_valid.
- flush together with a hazard: the flush wins and no bubble is counted.
- A WB write and a hazard in the same cycle: the write completes and the stall proceeds normally.

## Test plan
- Reset: drive resetn low mid-stream with ex_valid=1 → all ex_* outputs go to 0 immediately. After release, regfile reads return 0.
- Decode: write r1=5 via WB, then present addi r2,r1,-1 (0x2022FFFF) → next cycle ex_rdata1=5, ex_imm=0xFFFFFFFF, ex_dest=2, ex_aluop=000, ex_alusrc=1, ex_regwrite=1.
- Load-use: lw r3,0(r1) followed by add r4,r3,r1 → id_ready=0 for one cycle and ex_valid=0 for one cycle. The add then appears with ex_rs=3. A non-dependent instruction after the lw causes no stall.
- Bypass and r0: in the same cycle, wb writes r5=0xA5 and ID reads r5 → ex_rdata=0xA5. A wb write to r0 with 0xFF → a later read of r0 returns 0.
- Backpressure and flush: hold ex_ready=0 for 3 cycles → ex_* stable and id_ready=0. Then assert flush → ex_valid=0 next cycle and id_ready=1 during the flush.
- Illegal and lui: opcode 0x3F → ex_illegal=1 with all write and memory controls 0. lui r6,0x1234 → ex_imm=0x12340000 and ex_aluop=100.
